// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative 32-bit MULTU/DIVU unit with HI/LO registers and pipeline stall.
// Define MULDIV_EARLY_OUT_EN to finish trivial MULTU/DIVU cases after a single busy cycle.
module muldiv_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  alu_ctrl,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] result,
  output logic        div_by_zero
);
  localparam logic [3:0] MULTU = 4'd7;
  localparam logic [3:0] DIVU  = 4'd8;
  localparam logic [3:0] MFHI  = 4'd9;
  localparam logic [3:0] MFLO  = 4'd10;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] work_q, work_d;
  logic [31:0] opnd_q, opnd_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        dbz_q, dbz_d, busy_q, busy_d, done_q, done_d, early_q, early_d;
  logic        is_muldiv, accept, early, fin, ge;
  logic [63:0] init_work, nx_work, fin_work;
  logic [32:0] msum, ddiff;
  logic [64:0] dt;
  assign is_muldiv = (alu_ctrl == MULTU) || (alu_ctrl == DIVU) || (alu_ctrl == MFHI) || (alu_ctrl == MFLO);
  assign accept    = (state_q == IDLE) && start && ((alu_ctrl == MULTU) || (alu_ctrl == DIVU));
`ifdef MULDIV_EARLY_OUT_EN
  assign early     = (alu_ctrl == MULTU) ? (a == 32'd0 || b == 32'd0) : (b != 32'd0 && b > a);
  assign init_work = early ? ((alu_ctrl == MULTU) ? 64'd0 : {a, 32'd0})
                           : {32'd0, (alu_ctrl == MULTU) ? b : a};
`else
  assign early     = 1'b0;
  assign init_work = {32'd0, (alu_ctrl == MULTU) ? b : a};
`endif
  // MUL keeps {partial product, remaining multiplier}; DIV keeps {remainder, quotient}.
  assign msum     = {1'b0, work_q[63:32]} + {1'b0, work_q[0] ? opnd_q : 32'd0};
  assign dt       = {work_q, 1'b0};
  assign ddiff    = dt[64:32] - {1'b0, opnd_q};
  assign ge       = ~ddiff[32];
  assign nx_work  = (state_q == MUL) ? {msum, work_q[31:1]}
                  : (ge ? {ddiff[31:0], dt[31:1], 1'b1} : dt[63:0]);
  assign fin      = (cnt_q == 5'd31) || early_q;
  assign fin_work = early_q ? work_q : nx_work;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = dbz_q;
    early_d = early_q;
    if (state_q == IDLE) begin
      if (accept) begin
        state_d = (alu_ctrl == MULTU) ? MUL : DIV;
        cnt_d   = 5'd0;
        opnd_d  = (alu_ctrl == MULTU) ? a : b;
        work_d  = init_work;
        early_d = early;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end else begin
      cnt_d  = cnt_q + 5'd1;
      work_d = nx_work;
      if (fin) begin
        state_d = DONE;
        hi_d    = fin_work[63:32];
        lo_d    = fin_work[31:0];
        dbz_d   = dbz_q | ((state_q == DIV) && (opnd_q == 32'd0));
      end
    end
    busy_d = (state_d == MUL) || (state_d == DIV);
    done_d = (state_d == DONE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      work_q  <= 64'd0;
      opnd_q  <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      early_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      early_q <= early_d;
    end
  end
  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;
  assign stall       = start && (busy_q || state_q == DONE) && is_muldiv;
  assign result      = stall ? 32'd0 : (alu_ctrl == MFHI) ? hi_q : (alu_ctrl == MFLO) ? lo_q : 32'd0;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: randomized and directed checks of muldiv_sequencer against an arithmetic model.
module tb_muldiv_sequencer;
  localparam logic [3:0] MULTU = 4'd7;
  localparam logic [3:0] DIVU  = 4'd8;
  localparam logic [3:0] MFHI  = 4'd9;
  localparam logic [3:0] MFLO  = 4'd10;
  logic        clk, rst, start;
  logic [3:0]  alu_ctrl;
  logic [31:0] a, b;
  logic        busy, stall, done, div_by_zero;
  logic [31:0] hi, lo, result;
  int total = 0;
  int bad = 0;
  logic [31:0] exp_hi, exp_lo;
  logic        exp_dbz;
  int          exp_cyc;
  muldiv_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .alu_ctrl(alu_ctrl), .a(a), .b(b),
    .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo),
    .result(result), .div_by_zero(div_by_zero)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic model_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    if (op == MULTU) begin
      p = {32'd0, x} * {32'd0, y};
      exp_hi = p[63:32];
      exp_lo = p[31:0];
    end else if (y == 32'd0) begin
      exp_hi = x;
      exp_lo = 32'hFFFFFFFF;
      exp_dbz = 1'b1;
    end else begin
      exp_hi = x % y;
      exp_lo = x / y;
    end
    exp_cyc = 32;
`ifdef MULDIV_EARLY_OUT_EN
    if ((op == MULTU && (x == 0 || y == 0)) || (op == DIVU && y != 0 && y > x)) exp_cyc = 1;
`endif
  endtask
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    int n;
    model_op(op, x, y);
    alu_ctrl = op; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0; alu_ctrl = 4'd0; a = $urandom; b = $urandom;
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
    total++; if (n != exp_cyc) begin bad++; $display("FAIL %s busy_cycles got=%0d want=%0d", name, n, exp_cyc); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL %s done got=%b want=1", name, done); end
    total++; if (hi !== exp_hi) begin bad++; $display("FAIL %s hi got=%h want=%h", name, hi, exp_hi); end
    total++; if (lo !== exp_lo) begin bad++; $display("FAIL %s lo got=%h want=%h", name, lo, exp_lo); end
    total++; if (div_by_zero !== exp_dbz) begin bad++; $display("FAIL %s dbz got=%b want=%b", name, div_by_zero, exp_dbz); end
    tick();
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL %s after_done done=%b busy=%b want 0 0", name, done, busy); end
  endtask
  task automatic test_reset();
    rst = 1'b1; start = 1'b1; alu_ctrl = MULTU; a = 32'd3; b = 32'd4;
    tick(); tick();
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset busy/done got=%b%b want=00", busy, done); end
    total++; if (hi !== 32'd0 || lo !== 32'd0) begin bad++; $display("FAIL reset hilo got=%h/%h want=0/0", hi, lo); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset dbz got=%b want=0", div_by_zero); end
    rst = 1'b0; start = 1'b0; alu_ctrl = MFHI;
    #1;
    total++; if (stall !== 1'b0 || result !== 32'd0) begin bad++; $display("FAIL reset stall/result got=%b/%h want=0/0", stall, result); end
    exp_hi = 0; exp_lo = 0; exp_dbz = 0;
    tick();
  endtask
  task automatic test_reads(input string name);
    start = 1'b1; alu_ctrl = MFHI; #1;
    total++; if (result !== exp_hi || stall !== 1'b0) begin bad++; $display("FAIL %s mfhi got=%h stall=%b want=%h", name, result, stall, exp_hi); end
    alu_ctrl = MFLO; #1;
    total++; if (result !== exp_lo) begin bad++; $display("FAIL %s mflo got=%h want=%h", name, result, exp_lo); end
    alu_ctrl = 4'd3; #1;
    total++; if (result !== 32'd0 || stall !== 1'b0) begin bad++; $display("FAIL %s other got=%h stall=%b want=0", name, result, stall); end
    tick();
    total++; if (busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin bad++; $display("FAIL %s no_accept busy=%b hi=%h lo=%h", name, busy, hi, lo); end
    start = 1'b0;
  endtask
  task automatic test_directed();
    run_op("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    total++; if (exp_hi !== 32'hFFFFFFFE || exp_lo !== 32'h00000001) begin bad++; $display("FAIL model_max got=%h_%h", exp_hi, exp_lo); end
    run_op("divu_100_7", DIVU, 32'd100, 32'd7);
    test_reads("reads_div");
    run_op("divu_by0", DIVU, 32'd5, 32'd0);
    run_op("multu_after_dbz", MULTU, 32'd12345, 32'd678);
    test_reads("reads_mul");
  endtask
  task automatic test_stall();
    logic [31:0] x, y;
    int k;
    x = $urandom | 32'h1; y = $urandom | 32'h1;
    alu_ctrl = MULTU; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0; alu_ctrl = 4'd0;
    tick(); tick();
    model_op(MULTU, x, y);
    start = 1'b1; alu_ctrl = MFLO; #1;
    k = 0;
    while (busy && k < 60) begin
      total++; if (stall !== 1'b1 || result !== 32'd0) begin bad++; $display("FAIL stall_busy cyc=%0d stall=%b result=%h want 1/0", k, stall, result); end
      k++;
      tick();
    end
    total++; if (done !== 1'b1 || stall !== 1'b1 || result !== 32'd0) begin bad++; $display("FAIL stall_done done=%b stall=%b result=%h", done, stall, result); end
    tick();
    total++; if (stall !== 1'b0 || result !== exp_lo) begin bad++; $display("FAIL stall_idle stall=%b result=%h want 0/%h", stall, result, exp_lo); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL stall_no_accept busy=%b want 0", busy); end
    start = 1'b0;
  endtask
  task automatic test_ignore();
    start = 1'b1; alu_ctrl = 4'd2; a = 32'd9; b = 32'd9;
    tick();
    total++; if (busy !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL ignore_idle busy=%b stall=%b want 0 0", busy, stall); end
    alu_ctrl = DIVU; a = 32'hFFFF0000; b = 32'd3;
    tick();
    alu_ctrl = 4'd12; #1;
    total++; if (stall !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL ignore_busy stall=%b busy=%b want 0 1", stall, busy); end
    start = 1'b0;
    model_op(DIVU, 32'hFFFF0000, 32'd3);
    while (busy) tick();
    total++; if (lo !== exp_lo || hi !== exp_hi) begin bad++; $display("FAIL ignore_result got=%h/%h want=%h/%h", hi, lo, exp_hi, exp_lo); end
    tick();
  endtask
  task automatic test_reset_mid();
    int k;
    alu_ctrl = MULTU; a = $urandom | 32'h1; b = $urandom | 32'h1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rst_mid busy/done got=%b%b want=00", busy, done); end
    total++; if (hi !== 32'd0 || lo !== 32'd0 || div_by_zero !== 1'b0) begin bad++; $display("FAIL rst_mid hi=%h lo=%h dbz=%b want 0", hi, lo, div_by_zero); end
    k = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) k++;
      tick();
    end
    total++; if (k != 0) begin bad++; $display("FAIL rst_mid_no_done active_cycles=%0d want=0", k); end
    exp_hi = 0; exp_lo = 0; exp_dbz = 0;
  endtask
  task automatic test_random();
    logic [31:0] x, y;
    logic [3:0] op;
    for (int i = 0; i < 24; i++) begin
      op = ($urandom_range(0, 1) == 0) ? MULTU : DIVU;
      x = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : $urandom;
      y = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom_range(0, 2) == 0) ? $urandom_range(1, 1000) : $urandom;
      run_op("random", op, x, y);
    end
  endtask
  task automatic test_early();
    run_op("multu_zero", MULTU, 32'd0, 32'd5);
    run_op("divu_small", DIVU, 32'd3, 32'd1000);
  endtask
  initial begin
    start = 1'b0; alu_ctrl = 4'd0; a = 32'd0; b = 32'd0; rst = 1'b1;
    test_reset();
    test_directed();
    test_stall();
    test_ignore();
    test_reset_mid();
    test_early();
    test_random();
    test_reads("reads_final");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; all state updates on the rising edge of clk.
REQ-002 SHALL have port clk  input  1  system clock.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port start  input  1  command valid from the decode/execute stage.
REQ-005 SHALL have port alu_ctrl  input  4  alu_ctrl_t command: MULTUac=7, DIVUac=8, MFHIac=9, MFLOac=10; other codes are ignored.
REQ-006 SHALL have port a  input  32  rs operand: multiplicand or dividend.
REQ-007 SHALL have port b  input  32  rt operand: multiplier or divisor.
REQ-008 SHALL have port busy  output  1  iterative operation in progress.
REQ-009 SHALL have port stall  output  1  combinational hold request to the pipeline.
REQ-010 SHALL have port done  output  1  one-cycle pulse when hi/lo are updated.
REQ-011 SHALL have port hi  output  32  HI register.
REQ-012 SHALL have port lo  output  32  LO register.
REQ-013 SHALL have port result  output  32  combinational MFHI/MFLO read data.
REQ-014 SHALL have port div_by_zero  output  1  sticky flag, set by a DIVU with b=0.

Function
REQ-015 SHALL implement states IDLE, MUL, DIV and DONE.
REQ-016 SHALL, in IDLE with start=1, accept MULTUac (go to MUL) or DIVUac (go to DIV), capture a/b, and clear the iteration counter to 0.
REQ-017 SHALL perform one iteration per cycle in MUL and DIV: unsigned shift-add for MUL, restoring shift-subtract for DIV, using a 64-bit working register.
REQ-018 SHALL run exactly 32 iterations: state moves to DONE on the edge where counter=31, and the counter is 5 bits.
REQ-019 SHALL hold busy=1 for exactly 32 cycles, starting the cycle after acceptance.
REQ-020 SHALL, in DONE, drive done=1 and busy=0 with hi/lo already updated, then return to IDLE on the next edge.
REQ-021 SHALL produce MULTU results as hi = product[63:32] and lo = product[31:0].
REQ-022 SHALL produce DIVU results as lo = quotient and hi = remainder.
REQ-023 SHALL, for DIVU with b=0, give lo=32'hFFFFFFFF, hi=a, and set div_by_zero; the flag is cleared only by reset.
REQ-024 SHALL drive stall = start & (busy | state==DONE) & alu_ctrl in {MULTUac, DIVUac, MFHIac, MFLOac}, so a new command is never accepted or lost while busy.
REQ-025 SHALL make commands accepted in DONE impossible: stall holds the command, and it is accepted in the following IDLE cycle.
REQ-026 SHALL drive result = hi when alu_ctrl=MFHIac and stall=0, lo when alu_ctrl=MFLOac and stall=0, and 0 otherwise.
REQ-027 SHALL ignore start with a non-muldiv alu_ctrl in all states, with no state change and no stall.
REQ-028 SHALL keep hi/lo unchanged between operations; an MFHI/MFLO never modifies state.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, set state=IDLE, counter=0, hi=0, lo=0, div_by_zero=0, busy=0 and done=0.
REQ-030 SHALL, on rst asserted mid-operation, abort the operation, discard the partial result, and drive busy=0 on the next cycle.
REQ-031 SHALL give rst priority over start when both are asserted on the same edge.

Configuration
REQ-032 SHALL support the macro MULDIV_EARLY_OUT_EN.
REQ-033 SHALL, when MULDIV_EARLY_OUT_EN is defined, complete the following cases after one busy cycle and then go to DONE with exact results: MULTU with a=0 or b=0 (hi=lo=0), and DIVU with b>a and b!=0 (lo=0, hi=a).
REQ-034 SHALL, when MULDIV_EARLY_OUT_EN is undefined, always use 32 busy cycles.

Verification
REQ-035 SHALL be checked with MULTU a=32'hFFFFFFFF, b=32'hFFFFFFFF -> 32 busy cycles, then done with hi=32'hFFFFFFFE, lo=32'h00000001.
REQ-036 SHALL be checked with DIVU a=100, b=7 -> lo=14, hi=2, div_by_zero=0.
REQ-037 SHALL be checked with DIVU a=5, b=0 -> lo=32'hFFFFFFFF, hi=5, and div_by_zero=1 staying set through a later MULTU.
REQ-038 SHALL be checked with MFLO held on start during busy cycle 3 -> stall=1 until DONE, then result=lo in the IDLE cycle.
REQ-039 SHALL be checked with rst pulsed in busy cycle 10 of a MULTU -> busy=0, hi=lo=0 next cycle, and no done pulse.
REQ-040 SHALL be checked, with MULDIV_EARLY_OUT_EN, using MULTU a=0, b=5 -> one busy cycle, done with hi=lo=0; without the macro -> 32 busy cycles and the same result.
